icache_ctrl: RTL and testbench

- Instruction-cache controller that sits directly upstream of the core's fetch stage.
- Accepts fetch requests (address, id, valid) from the core and returns instruction words with the echoed id and a ready pulse.
- Signals a stall while servicing a miss.
- Direct-mapped, read-only, blocking; misses fill a whole line from a word-wide backing-memory port, one outstanding read at a time.

---
 rtl/icache_ctrl_pkg.sv | 20 ++
 rtl/icache_tag_array.sv | 43 ++++
 rtl/icache_ctrl.sv | 167 ++++++++++++++++
 tb/tb_icache_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// rtl/icache_ctrl_pkg.sv - shared geometry and FSM encodings for the instruction cache
package icache_ctrl_pkg;

  // Default geometry; the top exposes these as overridable parameters.
  localparam int ICACHE_DATA_WIDTH = 32;
  localparam int ICACHE_ID_WIDTH   = 4;
  localparam int ICACHE_NUM_LINES  = 16;
  localparam int ICACHE_LINE_WORDS = 4;

  // Address split: {tag, index, offset, 2'b00}
  localparam int ICACHE_OFFSET_W = $clog2(ICACHE_LINE_WORDS);
  localparam int ICACHE_INDEX_W  = $clog2(ICACHE_NUM_LINES);
  localparam int ICACHE_TAG_W    = ICACHE_DATA_WIDTH - ICACHE_INDEX_W - ICACHE_OFFSET_W - 2;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/icache_tag_array.sv
// rtl/icache_tag_array.sv - valid/tag storage with combinational lookup, flush and fill write
module icache_tag_array
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = ICACHE_NUM_LINES,
  parameter int TAG_W     = ICACHE_TAG_W,
  parameter int INDEX_W   = $clog2(NUM_LINES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               lookup_hit,
  input  logic               flush_clear,
  input  logic               fill_we,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TAG_W-1:0]   fill_tag
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  assign lookup_hit = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);

  // Valid bits: cleared by reset or flush; a completed fill marks its line valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush_clear) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tags carry no reset; they are only meaningful behind a set valid bit
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_index] <= fill_tag;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped blocking instruction cache controller
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int ID_WIDTH   = ICACHE_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] core_addr_in,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  input  logic                  core_rw_in,
  input  logic [ID_WIDTH-1:0]   core_id_in,
  input  logic                  core_valid_in,
  output logic [DATA_WIDTH-1:0] core_data_out,
  output logic [ID_WIDTH-1:0]   core_id_out,
  output logic                  core_ready_out,
  output logic                  core_stall_out,
  input  logic                  flush_in,
  output logic [DATA_WIDTH-1:0] mem_addr_out,
  output logic                  mem_valid_out,
  input  logic                  mem_ready_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = DATA_WIDTH - INDEX_W - OFFSET_W - 2;
  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

  // Incoming address fields
  logic [OFFSET_W-1:0] in_offset;
  logic [INDEX_W-1:0]  in_index;
  logic [TAG_W-1:0]    in_tag;

  assign in_offset = core_addr_in[OFFSET_W+1:2];
  assign in_index  = core_addr_in[OFFSET_W+2 +: INDEX_W];
  assign in_tag    = core_addr_in[DATA_WIDTH-1 -: TAG_W];

  // Write data and the byte-lane bits have no function in a read-only cache
  logic unused_inputs;
  assign unused_inputs = ^{core_data_in, core_addr_in[1:0]};

  // Controller state and the latched request being serviced
  logic [1:0]          state_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic [INDEX_W-1:0]  req_index_q;
  logic [OFFSET_W-1:0] req_offset_q;
  logic [ID_WIDTH-1:0] req_id_q;
  logic [OFFSET_W-1:0] word_cnt_q;
  logic                flush_pend_q;

  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];

  logic tag_hit;
  logic accept;
  logic hit;
  logic miss;
  logic mem_accept;
  logic fill_last;
  logic flush_clear;

  // A flush in the same cycle as a request forces that request down the miss path
  assign accept      = core_valid_in && !core_stall_out && !core_rw_in && (state_q == ST_IDLE);
  assign hit         = accept && tag_hit && !flush_in;
  assign miss        = accept && !(tag_hit && !flush_in);
  assign mem_accept  = (state_q == ST_FILL) && mem_valid_out && mem_ready_in;
  assign fill_last   = mem_accept && (word_cnt_q == LAST_WORD);
  // Flushes seen during a fill are deferred until the response has gone out
  assign flush_clear = ((state_q == ST_IDLE) && flush_in) ||
                       ((state_q == ST_RESP) && (flush_pend_q || flush_in));

  icache_tag_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .INDEX_W   (INDEX_W)
  ) u_tag_array (
    .clk          (clk),
    .reset        (reset),
    .lookup_index (in_index),
    .lookup_tag   (in_tag),
    .lookup_hit   (tag_hit),
    .flush_clear  (flush_clear),
    .fill_we      (fill_last),
    .fill_index   (req_index_q),
    .fill_tag     (req_tag_q)
  );

  // Line data: each accepted fill beat lands in the word selected by the counter
  always_ff @(posedge clk) begin
    if (mem_accept) begin
      data_q[req_index_q][word_cnt_q] <= mem_data_in;
    end
  end

  // Request handling, line fill sequencing and the response pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      req_tag_q      <= '0;
      req_index_q    <= '0;
      req_offset_q   <= '0;
      req_id_q       <= '0;
      word_cnt_q     <= '0;
      flush_pend_q   <= 1'b0;
      core_data_out  <= '0;
      core_id_out    <= '0;
      core_ready_out <= 1'b0;
      core_stall_out <= 1'b0;
      mem_addr_out   <= '0;
      mem_valid_out  <= 1'b0;
    end else begin
      core_ready_out <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            core_ready_out <= 1'b1;
            core_data_out  <= data_q[in_index][in_offset];
            core_id_out    <= core_id_in;
          end else if (miss) begin
            state_q        <= ST_FILL;
            core_stall_out <= 1'b1;
            req_tag_q      <= in_tag;
            req_index_q    <= in_index;
            req_offset_q   <= in_offset;
            req_id_q       <= core_id_in;
            word_cnt_q     <= '0;
            mem_addr_out   <= {in_tag, in_index, {OFFSET_W{1'b0}}, 2'b00};
            mem_valid_out  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (flush_in) begin
            flush_pend_q <= 1'b1;
          end
          if (mem_accept) begin
            mem_valid_out <= 1'b0;
            if (word_cnt_q == LAST_WORD) begin
              state_q <= ST_RESP;
            end else begin
              word_cnt_q <= word_cnt_q + OFFSET_W'(1);
            end
          end else if (!mem_valid_out) begin
            mem_valid_out <= 1'b1;
            mem_addr_out  <= {req_tag_q, req_index_q, word_cnt_q, 2'b00};
          end
        end
        ST_RESP: begin
          core_ready_out <= 1'b1;
          core_data_out  <= data_q[req_index_q][req_offset_q];
          core_id_out    <= req_id_q;
          core_stall_out <= 1'b0;
          flush_pend_q   <= 1'b0;
          state_q        <= ST_IDLE;
        end
        default: begin
          state_q        <= ST_IDLE;
          core_stall_out <= 1'b0;
          mem_valid_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - scoreboard bench for the instruction cache controller
module tb_icache_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] core_addr_in;
  logic [31:0] core_data_in;
  logic        core_rw_in;
  logic [3:0]  core_id_in;
  logic        core_valid_in;
  logic [31:0] core_data_out;
  logic [3:0]  core_id_out;
  logic        core_ready_out;
  logic        core_stall_out;
  logic        flush_in;
  logic [31:0] mem_addr_out;
  logic        mem_valid_out;
  logic        mem_ready_in;
  logic [31:0] mem_data_in;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          mem_delay = 0;
  int          wait_cnt = 0;
  exp_t        sb_q[$];
  int          resp_cyc[$];
  logic [31:0] mem_log[$];

  icache_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .core_addr_in   (core_addr_in),
    .core_data_in   (core_data_in),
    .core_rw_in     (core_rw_in),
    .core_id_in     (core_id_in),
    .core_valid_in  (core_valid_in),
    .core_data_out  (core_data_out),
    .core_id_out    (core_id_out),
    .core_ready_out (core_ready_out),
    .core_stall_out (core_stall_out),
    .flush_in       (flush_in),
    .mem_addr_out   (mem_addr_out),
    .mem_valid_out  (mem_valid_out),
    .mem_ready_in   (mem_ready_in),
    .mem_data_in    (mem_data_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing memory contents: the 0x100 line holds 0xA0..0xA3, elsewhere an address pattern
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'hA0 + {30'd0, a[3:2]};
    return 32'hC0DE0000 | {16'h0, a[15:2], 2'b00};
  endfunction

  // Memory responder: answers a held request after mem_delay waiting cycles
  initial begin
    mem_ready_in = 1'b0;
    mem_data_in  = '0;
    forever begin
      @(negedge clk);
      mem_ready_in = 1'b0;
      if (mem_valid_out) begin
        if (wait_cnt >= mem_delay) begin
          mem_ready_in = 1'b1;
          mem_data_in  = mem_word(mem_addr_out);
          mem_log.push_back(mem_addr_out);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every ready pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (core_ready_out) begin
        resp_cyc.push_back(cyc);
        compared++;
        if (sb_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_resp: got data=%h id=%0d, required no response", core_data_out, core_id_out);
        end else begin
          e = sb_q.pop_front();
          if (core_data_out !== e.data || core_id_out !== e.id) begin
            mismatched++;
            $display("FAIL resp: got data=%h id=%0d, required data=%h id=%0d", core_data_out, core_id_out, e.data, e.id);
          end
        end
        compared++;
        if (core_stall_out !== 1'b0) begin
          mismatched++;
          $display("FAIL ready_with_stall: got stall=%b, required 0", core_stall_out);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] a, input logic [3:0] id);
    core_addr_in  = a;
    core_id_in    = id;
    core_rw_in    = 1'b0;
    core_valid_in = 1'b1;
    sb_q.push_back('{data: mem_word(a), id: id});
    @(negedge clk);
    core_valid_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    @(negedge clk);
    while ((core_stall_out || sb_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = !(core_stall_out || sb_q.size() != 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (core_data_out !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h, required 0", core_data_out); end
    compared++; if (core_id_out !== 4'h0) begin mismatched++; $display("FAIL reset_id: got %h, required 0", core_id_out); end
    compared++; if (core_ready_out !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b, required 0", core_ready_out); end
    compared++; if (core_stall_out !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b, required 0", core_stall_out); end
    compared++; if (mem_addr_out !== 32'h0) begin mismatched++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr_out); end
    compared++; if (mem_valid_out !== 1'b0) begin mismatched++; $display("FAIL reset_mem_valid: got %b, required 0", mem_valid_out); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_fill();
    int base;
    bit ok;
    base = mem_log.size();
    send(32'h100, 4'd3);
    compared++; if (core_stall_out !== 1'b1) begin mismatched++; $display("FAIL miss_stall: got %b, required 1", core_stall_out); end
    wait_done(300, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL miss_done: got timeout, required response"); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (mem_log.size() < base + 4 || mem_log[base+i] !== 32'h100 + 32'(4*i)) begin
        mismatched++;
        $display("FAIL miss_addr%0d: got %h, required %h", i, mem_log[base+i], 32'h100 + 32'(4*i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int nresp;
    bit ok;
    base  = mem_log.size();
    nresp = resp_cyc.size();
    core_rw_in    = 1'b0;
    core_valid_in = 1'b1;
    core_addr_in  = 32'h108; core_id_in = 4'd5;
    sb_q.push_back('{data: mem_word(32'h108), id: 4'd5});
    @(negedge clk);
    core_addr_in  = 32'h104; core_id_in = 4'd6;
    sb_q.push_back('{data: mem_word(32'h104), id: 4'd6});
    @(negedge clk);
    core_valid_in = 1'b0;
    wait_done(50, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL b2b_done: got timeout, required responses"); end
    compared++; if (mem_log.size() != base) begin mismatched++; $display("FAIL b2b_mem: got %0d reads, required 0", mem_log.size() - base); end
    compared++;
    if (resp_cyc.size() != nresp + 2 || resp_cyc[nresp+1] - resp_cyc[nresp] != 1) begin
      mismatched++;
      $display("FAIL b2b_spacing: got %0d responses, required 2 on consecutive cycles", resp_cyc.size() - nresp);
    end
  endtask

  task automatic test_alias();
    int base;
    bit ok;
    base = mem_log.size();
    send(32'h500, 4'd1);
    compared++; if (core_stall_out !== 1'b1) begin mismatched++; $display("FAIL alias_stall: got %b, required 1", core_stall_out); end
    wait_done(300, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL alias_done: got timeout, required response"); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (mem_log.size() < base + 4 || mem_log[base+i] !== 32'h500 + 32'(4*i)) begin
        mismatched++;
        $display("FAIL alias_addr%0d: got %h, required %h", i, mem_log[base+i], 32'h500 + 32'(4*i));
      end
    end
    base = mem_log.size();
    send(32'h100, 4'd2);
    wait_done(300, ok);
    compared++; if (!ok || mem_log.size() - base != 4) begin mismatched++; $display("FAIL alias_refill: got %0d reads, required 4", mem_log.size() - base); end
  endtask

  task automatic test_flush_idle();
    int base;
    bit ok;
    base = mem_log.size();
    flush_in = 1'b1;
    send(32'h10C, 4'd8);
    flush_in = 1'b0;
    wait_done(300, ok);
    compared++; if (!ok || mem_log.size() - base != 4) begin mismatched++; $display("FAIL flush_idle_miss: got %0d reads, required 4", mem_log.size() - base); end
    base = mem_log.size();
    send(32'h104, 4'd9);
    wait_done(50, ok);
    compared++; if (!ok || mem_log.size() != base) begin mismatched++; $display("FAIL flush_idle_rehit: got %0d reads, required 0", mem_log.size() - base); end
  endtask

  task automatic test_slow_mem();
    int base;
    int n;
    bit ok;
    bit prev_valid;
    logic [31:0] prev_addr;
    mem_delay = 5;
    base = mem_log.size();
    send(32'h700, 4'd7);
    prev_valid = 1'b0;
    prev_addr  = '0;
    n = 0;
    while (mem_log.size() - base < 4 && n < 400) begin
      @(posedge clk);
      #2;
      compared++;
      if (core_stall_out !== 1'b1) begin mismatched++; $display("FAIL slow_stall: got %b, required 1", core_stall_out); end
      if (prev_valid && !mem_ready_in) begin
        compared++;
        if (mem_valid_out !== 1'b1 || mem_addr_out !== prev_addr) begin
          mismatched++;
          $display("FAIL slow_hold: got valid=%b addr=%h, required valid=1 addr=%h", mem_valid_out, mem_addr_out, prev_addr);
        end
      end
      prev_valid = mem_valid_out;
      prev_addr  = mem_addr_out;
      n++;
    end
    mem_delay = 0;
    wait_done(300, ok);
    compared++; if (!ok || mem_log.size() - base != 4) begin mismatched++; $display("FAIL slow_done: got %0d reads, required 4", mem_log.size() - base); end
  endtask

  task automatic test_flush_midfill();
    int base;
    int n;
    bit ok;
    base = mem_log.size();
    send(32'h200, 4'd2);
    n = 0;
    while (mem_log.size() - base < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    wait_done(300, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL flush_fill_resp: got timeout, required response"); end
    base = mem_log.size();
    send(32'h200, 4'd4);
    wait_done(300, ok);
    compared++; if (!ok || mem_log.size() - base != 4) begin mismatched++; $display("FAIL flush_fill_miss: got %0d reads, required 4", mem_log.size() - base); end
  endtask

  task automatic test_write_drop();
    int base;
    int nresp;
    base  = mem_log.size();
    nresp = resp_cyc.size();
    core_rw_in    = 1'b1;
    core_valid_in = 1'b1;
    core_addr_in  = 32'hA00; core_id_in = 4'd1;
    @(negedge clk);
    core_addr_in  = 32'h200; core_id_in = 4'd2;
    @(negedge clk);
    core_valid_in = 1'b0;
    core_rw_in    = 1'b0;
    repeat (6) @(negedge clk);
    compared++; if (mem_log.size() != base) begin mismatched++; $display("FAIL write_mem: got %0d reads, required 0", mem_log.size() - base); end
    compared++; if (resp_cyc.size() != nresp) begin mismatched++; $display("FAIL write_resp: got %0d responses, required 0", resp_cyc.size() - nresp); end
    compared++; if (core_stall_out !== 1'b0) begin mismatched++; $display("FAIL write_stall: got %b, required 0", core_stall_out); end
  endtask

  task automatic test_reset_midfill();
    int base;
    int n;
    bit ok;
    base = mem_log.size();
    send(32'h900, 4'hC);
    n = 0;
    while (mem_log.size() - base < 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    compared++; if (core_data_out !== 32'h0) begin mismatched++; $display("FAIL rst_mid_data: got %h, required 0", core_data_out); end
    compared++; if (core_id_out !== 4'h0) begin mismatched++; $display("FAIL rst_mid_id: got %h, required 0", core_id_out); end
    compared++; if (core_ready_out !== 1'b0) begin mismatched++; $display("FAIL rst_mid_ready: got %b, required 0", core_ready_out); end
    compared++; if (core_stall_out !== 1'b0) begin mismatched++; $display("FAIL rst_mid_stall: got %b, required 0", core_stall_out); end
    compared++; if (mem_addr_out !== 32'h0) begin mismatched++; $display("FAIL rst_mid_mem_addr: got %h, required 0", mem_addr_out); end
    compared++; if (mem_valid_out !== 1'b0) begin mismatched++; $display("FAIL rst_mid_mem_valid: got %b, required 0", mem_valid_out); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = mem_log.size();
    send(32'h900, 4'hD);
    wait_done(300, ok);
    compared++; if (!ok || mem_log.size() - base != 4) begin mismatched++; $display("FAIL rst_mid_remiss: got %0d reads, required 4", mem_log.size() - base); end
  endtask

  initial begin
    reset         = 1'b0;
    core_addr_in  = '0;
    core_data_in  = '0;
    core_rw_in    = 1'b0;
    core_id_in    = '0;
    core_valid_in = 1'b0;
    flush_in      = 1'b0;
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_alias();
    test_flush_idle();
    test_slow_mem();
    test_flush_midfill();
    test_write_drop();
    test_reset_midfill();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
